// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory stage: pipeline payload structs,
// LSU state encoding and access-size codes.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } lsu_state_e;

    typedef struct packed {
        logic [2:0]      funct3;
        logic            mm_re;
        logic            mm_we;
        logic [XLEN-1:0] mm_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
    } memory_signals;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
    } writeback_signals;

endpackage

// File: rtl/lsu_mem_align.sv
// Combinational lane logic: store data replication and byte enables,
// access legality/alignment check, and load lane extract with extension.
module lsu_mem_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = lsu_pkg::XLEN,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [2:0]       req_funct3,
    input  logic [OFF_W-1:0] req_off,
    input  logic [XLEN-1:0]  req_data,
    output logic [XLEN-1:0]  req_wdata,
    output logic [BE_W-1:0]  req_be,
    output logic             req_bad,
    input  logic [2:0]       rsp_funct3,
    input  logic [OFF_W-1:0] rsp_off,
    input  logic [XLEN-1:0]  rsp_rdata,
    output logic [XLEN-1:0]  rsp_data
);

    // Widest legal unsigned-capable size is one below the native word.
    localparam logic [1:0] TOP_SZ = (XLEN == 64) ? SZ_D : SZ_W;

    logic [BE_W-1:0] size_mask;
    logic [XLEN-1:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        size_mask = '0;
        req_wdata = '0;
        req_bad   = 1'b0;
        unique case (req_funct3[1:0])
            SZ_B: begin
                size_mask = BE_W'(1);
                req_wdata = {BE_W{req_data[7:0]}};
            end
            SZ_H: begin
                size_mask = BE_W'(3);
                req_wdata = {(BE_W/2){req_data[15:0]}};
                req_bad   = req_off[0];
            end
            SZ_W: begin
                size_mask = BE_W'(15);
                req_wdata = {(BE_W/4){req_data[31:0]}};
                req_bad   = |req_off[1:0];
            end
            default: begin
                if (XLEN == 64) begin
                    size_mask = '1;
                    req_wdata = req_data;
                    req_bad   = |req_off;
                end else begin
                    req_bad   = 1'b1;
                end
            end
        endcase
        if (req_funct3[2] && (req_funct3[1:0] >= TOP_SZ))
            req_bad = 1'b1;
        req_be = size_mask << req_off;
    end

    assign shifted = rsp_rdata >> {rsp_off, 3'b000};

    always_comb begin
        rsp_data = shifted;
        unique case (rsp_funct3[1:0])
            SZ_B: rsp_data = rsp_funct3[2] ? XLEN'(shifted[7:0])
                                           : XLEN'($signed(shifted[7:0]));
            SZ_H: rsp_data = rsp_funct3[2] ? XLEN'(shifted[15:0])
                                           : XLEN'($signed(shifted[15:0]));
            SZ_W: rsp_data = rsp_funct3[2] ? XLEN'(shifted[31:0])
                                           : XLEN'($signed(shifted[31:0]));
            default: rsp_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory stage: passes ALU results through, runs one byte/half/word bus
// access at a time over req/ack, and returns writeback data under valid/ready.
module lsu
    import lsu_pkg::*;
#(
    parameter  int XLEN = lsu_pkg::XLEN,
    localparam int BE_W = XLEN / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  memory_signals    signals_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output writeback_signals signals_out,
    output logic             misaligned,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [BE_W-1:0]  mem_be,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ack
);

    localparam int OFF_W = $clog2(BE_W);

    lsu_state_e       state;
    logic [4:0]       rsp_rd;
    logic [2:0]       rsp_funct3;
    logic [OFF_W-1:0] rsp_off;

    logic             accept;
    logic             is_mem;
    logic             bad_access;
    logic             align_bad;
    logic [XLEN-1:0]  st_wdata;
    logic [BE_W-1:0]  st_be;
    logic [XLEN-1:0]  ld_data;

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_mem     = signals_in.mm_re || signals_in.mm_we;
    // Stores have no extension, so an "unsigned" store code is illegal too.
    assign bad_access = align_bad || (signals_in.mm_we && signals_in.funct3[2]);

    lsu_mem_align #(.XLEN(XLEN)) u_align (
        .req_funct3 (signals_in.funct3),
        .req_off    (signals_in.mm_addr[OFF_W-1:0]),
        .req_data   (signals_in.data),
        .req_wdata  (st_wdata),
        .req_be     (st_be),
        .req_bad    (align_bad),
        .rsp_funct3 (rsp_funct3),
        .rsp_off    (rsp_off),
        .rsp_rdata  (mem_rdata),
        .rsp_data   (ld_data)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            misaligned  <= 1'b0;
            signals_out <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            rsp_rd      <= '0;
            rsp_funct3  <= '0;
            rsp_off     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        misaligned <= 1'b0;
                    end
                    if (accept) begin
                        if (!is_mem) begin
                            out_valid   <= 1'b1;
                            misaligned  <= 1'b0;
                            signals_out <= '{rd_addr: signals_in.rd_addr, data: signals_in.data};
                        end else if (bad_access) begin
                            out_valid   <= 1'b1;
                            misaligned  <= 1'b1;
                            signals_out <= '0;
                        end else begin
                            state      <= BUS;
                            mem_req    <= 1'b1;
                            mem_we     <= signals_in.mm_we;
                            mem_addr   <= {signals_in.mm_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata  <= st_wdata;
                            mem_be     <= st_be;
                            rsp_rd     <= signals_in.mm_we ? 5'd0 : signals_in.rd_addr;
                            rsp_funct3 <= signals_in.funct3;
                            rsp_off    <= signals_in.mm_addr[OFF_W-1:0];
                        end
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        state       <= RESP;
                        mem_req     <= 1'b0;
                        out_valid   <= 1'b1;
                        misaligned  <= 1'b0;
                        signals_out <= '{rd_addr: rsp_rd, data: mem_we ? '0 : ld_data};
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
